// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants for the seven-segment scan decoder
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-high {g,f,e,d,c,b,a} pattern for hex digits 0..F
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational active-high 7-segment pattern to hex decoder
module seg7_to_hex
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] hex
);

  always_comb begin
    valid = 1'b0;
    hex   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_PATTERNS[i]) begin
        valid = 1'b1;
        hex   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// rtl/sseg_scan_decoder.sv - recovers four hex digits and decimal points from a scanned display bus
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] an,
  input  logic [6:0] sseg,
  input  logic       dp,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp_out,
  output logic       frame_tick,
  output logic       frame_valid,
  output logic       seg_error
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(SETTLE_CYCLES - 1);

  logic [11:0]           bus_q;
  logic [11:0]           bus;
  logic [11:0]           bus_p;
  logic [CW-1:0]         cnt;
  state_t                state;
  logic [NUM_DIGITS-1:0] mask;
  logic [3:0]            stage [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] stage_dp;

  logic [3:0] cur_an;
  logic       pat_valid;
  logic [3:0] pat_hex;
  logic       changed;
  logic       one_hot;
  logic       eval;
  logic       capture;
  logic       error;

  // Input register carries no reset: the settle counter ignores whatever it held before
  always_ff @(posedge CLK) begin
    bus_q <= {an, sseg, dp};
    bus_p <= bus;
  end

  assign bus    = ACTIVE_LOW ? ~bus_q : bus_q;
  assign cur_an = bus[11:8];

  seg7_to_hex u_dec (
    .pattern (bus[7:1]),
    .valid   (pat_valid),
    .hex     (pat_hex)
  );

  assign changed = (bus != bus_p);
  assign one_hot = (cur_an != 4'h0) && ((cur_an & (cur_an - 4'd1)) == 4'h0);
  assign eval    = (state == SETTLE) && !changed && (cnt == LAST_COUNT);
  assign capture = eval && one_hot && pat_valid;
  assign error   = eval && (cur_an != 4'h0) && !(one_hot && pat_valid);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= SETTLE;
      cnt         <= '0;
      mask        <= '0;
      stage_dp    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) stage[i] <= 4'h0;
      digit0      <= 4'h0;
      digit1      <= 4'h0;
      digit2      <= 4'h0;
      digit3      <= 4'h0;
      dp_out      <= 4'h0;
      frame_tick  <= 1'b0;
      frame_valid <= 1'b0;
      seg_error   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      seg_error  <= error;

      if (changed) cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;

      case (state)
        SETTLE:  if (eval) state <= HOLD;
        HOLD:    if (changed) state <= SETTLE;
        default: state <= SETTLE;
      endcase

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && cur_an[i]) begin
          stage[i]    <= pat_hex;
          stage_dp[i] <= bus[0];
        end
      end

      // Publishing uses the staging snapshot from before this cycle's capture
      if (mask == '1) begin
        digit0      <= stage[0];
        digit1      <= stage[1];
        digit2      <= stage[2];
        digit3      <= stage[3];
        dp_out      <= stage_dp;
        frame_tick  <= 1'b1;
        frame_valid <= 1'b1;
        mask        <= capture ? cur_an : '0;
      end else if (capture) begin
        mask <= mask | cur_an;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb/tb_sseg_scan_decoder.sv - randomized self-checking bench for sseg_scan_decoder
module tb_sseg_scan_decoder;

  localparam int S = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic [3:0] digit0, digit1, digit2, digit3, dp_out;
  logic       frame_tick, frame_valid, seg_error;

  always #5 CLK = ~CLK;

  sseg_scan_decoder #(.SETTLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .an(an), .sseg(sseg), .dp(dp),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dp_out(dp_out), .frame_tick(frame_tick), .frame_valid(frame_valid),
    .seg_error(seg_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [6:0] ref_seg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: each dwell (run of identical bus values) is judged once by its length
  logic [19:0] exp_frames [$];
  logic [3:0]  exp_mask;
  logic [3:0]  exp_stage [4];
  logic [3:0]  exp_sdp;
  int          exp_err;
  logic [11:0] prev_bus;
  bit          have_prev;
  bit          evaluated;
  int          run_len;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (ref_seg[i] == p) return i;
    return -1;
  endfunction

  task automatic model_clear();
    exp_frames.delete();
    exp_mask  = 4'h0;
    exp_sdp   = 4'h0;
    for (int i = 0; i < 4; i++) exp_stage[i] = 4'h0;
    exp_err   = 0;
    have_prev = 1'b0;
    evaluated = 1'b0;
    run_len   = 0;
  endtask

  task automatic model_dwell(input logic [3:0] a, input logic [6:0] s, input logic d, input int len);
    logic [11:0] b;
    int idx;
    b = {a, s, d};
    if (have_prev && b == prev_bus) run_len += len;
    else begin
      run_len   = len;
      evaluated = 1'b0;
    end
    prev_bus  = b;
    have_prev = 1'b1;
    if (!evaluated && run_len >= S + 1) begin
      evaluated = 1'b1;
      if (a == 4'h0) begin
      end else if ($countones(a) != 1) exp_err++;
      else begin
        idx = lookup(s);
        if (idx < 0) exp_err++;
        else begin
          for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
              exp_stage[i] = 4'(idx);
              exp_sdp[i]   = d;
            end
          end
          exp_mask |= a;
          if (exp_mask == 4'hF) begin
            exp_frames.push_back({exp_sdp, exp_stage[3], exp_stage[2], exp_stage[1], exp_stage[0]});
            exp_mask = 4'h0;
          end
        end
      end
    end
  endtask

  // Drives active-high values onto the active-low bus for len samples
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input logic d, input int len);
    model_dwell(a, s, d, len);
    an   = ~a;
    sseg = ~s;
    dp   = ~d;
    repeat (len) @(posedge CLK);
    #1;
  endtask

  task automatic dig(input logic [3:0] a, input int h, input logic d);
    dwell(a, ref_seg[h], d, 32);
  endtask

  // Monitor: every published frame must match the model's queue in order
  logic [19:0] mon_cur;
  int          mon_ticks;
  int          mon_err;

  always @(negedge CLK) begin
    if (RESET) begin
      mon_cur   = 20'h0;
      mon_ticks = 0;
      mon_err   = 0;
    end else begin
      if (frame_tick) begin
        if (mon_ticks >= exp_frames.size()) check("tick_unexpected", 32'd1, 32'd0);
        else begin
          check("frame", {dp_out, digit3, digit2, digit1, digit0}, exp_frames[mon_ticks]);
          mon_cur = exp_frames[mon_ticks];
        end
        mon_ticks++;
      end else begin
        check("hold", {dp_out, digit3, digit2, digit1, digit0}, mon_cur);
      end
      check("frame_valid", frame_valid, mon_ticks > 0);
      if (seg_error) mon_err++;
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_clear();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_d0"}, digit0, 0);
    check({tag, "_d1"}, digit1, 0);
    check({tag, "_d2"}, digit2, 0);
    check({tag, "_d3"}, digit3, 0);
    check({tag, "_dp"}, dp_out, 0);
    check({tag, "_tick"}, frame_tick, 0);
    check({tag, "_valid"}, frame_valid, 0);
    check({tag, "_err"}, seg_error, 0);
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int         len;

    an    = 4'hF;
    sseg  = 7'h7F;
    dp    = 1'b1;
    RESET = 1'b1;
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    do_reset();
    check_zero("reset");

    // Basic frame 4,3,2,1
    dig(4'b0001, 4, 1'b0); dig(4'b0010, 3, 1'b0); dig(4'b0100, 2, 1'b0); dig(4'b1000, 1, 1'b0);
    check("f1_d0", digit0, 4);
    check("f1_d1", digit1, 3);
    check("f1_d2", digit2, 2);
    check("f1_d3", digit3, 1);
    check("f1_valid", frame_valid, 1);

    // Short glitch on digit1 is ignored
    dig(4'b0001, 4, 1'b0); dig(4'b0010, 3, 1'b0);
    dwell(4'b0010, ref_seg[8], 1'b0, 8);
    dig(4'b0100, 2, 1'b0); dig(4'b1000, 1, 1'b0);
    check("glitch_d1", digit1, 3);

    // Blank pattern and multi-anode dwells raise errors without capturing
    dwell(4'b0001, 7'h00, 1'b0, 32);
    check("blank_err", mon_err, exp_err);
    dig(4'b0010, 6, 1'b0); dig(4'b0100, 7, 1'b0); dig(4'b1000, 9, 1'b0);
    dwell(4'b0011, ref_seg[5], 1'b0, 32);
    check("multi_err", mon_err, exp_err);
    dig(4'b0001, 0, 1'b0);
    check("blank_d0", digit0, 0);

    // Decimal point only on position 2
    dig(4'b0001, 13, 1'b0); dig(4'b0010, 12, 1'b0); dig(4'b0100, 11, 1'b1); dig(4'b1000, 10, 1'b0);
    check("dp_out", dp_out, 4'b0100);
    check("dp_d0", digit0, 4'hD);
    check("dp_d3", digit3, 4'hA);

    // Reset mid-frame discards the partial frame
    dig(4'b0001, 7, 1'b0); dig(4'b0010, 8, 1'b0); dig(4'b0100, 9, 1'b0);
    do_reset();
    check_zero("midreset");
    dig(4'b1000, 6, 1'b0);
    check("midreset_notick", frame_valid, 0);
    dig(4'b0001, 5, 1'b1); dig(4'b0010, 14, 1'b0); dig(4'b0100, 15, 1'b0); dig(4'b1000, 2, 1'b0);
    check("midreset_frame", frame_valid, 1);

    // Settle boundary: S+1 samples capture, S samples do not
    dwell(4'b0001, ref_seg[1], 1'b0, S + 1);
    dwell(4'b0001, ref_seg[14], 1'b0, S);
    dig(4'b0010, 2, 1'b0); dig(4'b0100, 3, 1'b0); dig(4'b1000, 4, 1'b0);
    check("boundary_d0", digit0, 1);

    // Randomized dwells
    for (int n = 0; n < 220; n++) begin
      case ($urandom_range(0, 9))
        0: a = 4'h0;
        1: begin
          a = 4'($urandom_range(0, 15));
          while ($countones(a) < 2) a = 4'($urandom_range(0, 15));
        end
        default: a = 4'(1 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 9) == 0) s = 7'($urandom_range(0, 127));
      else s = ref_seg[$urandom_range(0, 15)];
      if ($urandom_range(0, 2) == 0) len = $urandom_range(2, 12);
      else len = $urandom_range(S + 4, S + 20);
      dwell(a, s, 1'($urandom_range(0, 1)), len);
    end

    dwell(4'h0, 7'h00, 1'b0, S + 8);
    check("final_frames", mon_ticks, exp_frames.size());
    check("final_errors", mon_err, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment driver: samples the scanned an/sseg/dp bus and recovers the four displayed hex digits and decimal points.
- Used as an on-chip display self-check and as a bench monitor in the parking-meter design, tapping the same an/sseg/dp nets the display driver produces.
- Publishes a coherent 4-digit frame only after every digit position has been captured with stable segments.

Parameters:
- SETTLE_CYCLES, 16: number of consecutive CLK cycles the {an, sseg, dp} bus must hold unchanged before it is sampled; minimum value 2.
- ACTIVE_LOW, 1: 1 means an, sseg and dp are active-low (segment/anode lit = 0); 0 means active-high.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous reset, active-high.
- an  input  4  scanned anode enables; an[0] selects digit0 (rightmost) and an[3] selects digit3.
- sseg  input  7  segment bus; sseg[0]=a, sseg[1]=b, ... sseg[6]=g.
- dp  input  1  decimal point for the currently selected digit.
- digit0..digit3  output  4 each  recovered hex value for each position.
- dp_out  output  4  recovered decimal point per position; bit i belongs to digit i.
- frame_tick  output  1  one-cycle pulse when digit0..3 and dp_out update.
- frame_valid  output  1  sticky; set at the first frame_tick after reset.
- seg_error  output  1  one-cycle pulse on an undecodable dwell.

Behaviour:
- Reset: the following clear on the first CLK edge with RESET=1:
  - digit0..3 = 0, dp_out = 0, frame_tick = 0, frame_valid = 0, seg_error = 0.
  - Capture mask = 0, staging registers = 0, settle counter = 0, FSM = SETTLE.
  - Reset asserted mid-frame discards the partial frame.
- Input stage:
  - {an, sseg, dp} is registered once.
  - When ACTIVE_LOW=1 the registered value is inverted, so all internal logic is active-high.
- Segment table (active-high, {g..a}), hex value → pattern:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
  - Any other pattern is invalid.
- Settle counter:
  - Saturating counter, width $clog2(SETTLE_CYCLES)+1.
  - Clears to 0 on any cycle where the registered bus differs from its previous value.
  - Otherwise increments.
- FSM states and transitions:
  - SETTLE: counting. On the cycle the count reaches SETTLE_CYCLES-1 with the bus unchanged, evaluate the dwell (below), then move to HOLD.
  - HOLD: dwell has been evaluated; nothing is re-evaluated. Any bus change moves to SETTLE with count 0.
  - Result: each dwell is evaluated exactly once, however long it lasts.
- Dwell evaluation:
  - an == 0 (blanking interval): no action, no error.
  - an one-hot, pattern valid: write the hex value and dp into staging slot i and set mask[i].
  - an one-hot, pattern invalid: pulse seg_error; mask unchanged.
  - an with more than one bit set: pulse seg_error; no capture.
- Repeat capture:
  - Capturing a position whose mask bit is already set overwrites that staging slot.
  - The mask is unchanged.
- Frame completion:
  - On the cycle after the mask becomes 1111: copy staging to digit0..3 and dp_out, pulse frame_tick, set frame_valid, clear the mask.
  - A capture in that same cycle lands in the cleared mask and counts toward the next frame.
- Latency: frame_tick rises 1 (input register) + SETTLE_CYCLES + 1 CLK cycles after the bus settles on the final missing digit.
- Output holding: outputs do not change between frame_ticks.

Decomposition:
- Shared package sseg_pkg holds:
  - The 16-entry active-high segment pattern constants.
  - The FSM state encoding (SETTLE, HOLD).
  - The digit-count constant 4.
- One sub-module, seg7_to_hex: combinational 7-bit pattern → {valid, hex[3:0]} decoder, reusable by other display checks.
- The settle counter, FSM, mask and staging live in the top block.

Test Plan:
- Frame capture: scan an=1110/1101/1011/0111 with active-low patterns for 4,3,2,1, 32-cycle dwells → one frame_tick; digit0=4, digit1=3, digit2=2, digit3=1; frame_valid=1.
- Glitch rejection: insert an 8-cycle dwell of "8" on digit1 mid-frame (SETTLE_CYCLES=16) → ignored; digit1 keeps the value from its full-length dwell.
- Blank pattern: sseg=7'h7F (active-low, all segments off) with an=1110 for 32 cycles → single seg_error pulse; no frame_tick until digit0 is rescanned validly.
- Multiple anodes: an=1100 with a valid "5" for 32 cycles → seg_error pulse; mask unchanged.
- Decimal point: dp low only while an=1011 over a full scan of A,b,C,d → dp_out=4'b0100; digits 0..3=d,C,b,A... in that order digit0=d, digit1=C, digit2=b, digit3=A with digit3 scanned last (an=0111).
- Reset mid-frame: RESET for 1 cycle after 3 digits captured → all outputs 0; the next frame needs all 4 digits before frame_tick.
